// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-bit synchronizer, stability-count debouncer with press/release pulses
// Define BUTTON_DEBOUNCER_TOGGLE_EN to build the press-toggled toggle_o state; otherwise toggle_o is 0.
module button_debouncer #(
  parameter int width_p         = 3,
  parameter int stable_cycles_p = 12000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] btn_async_unsafe_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] rise_o,
  output logic [width_p-1:0] fall_o,
  output logic [width_p-1:0] toggle_o
);

  generate
    if (stable_cycles_p < 1) begin : g_bad_stable_cycles
      $error("button_debouncer: stable_cycles_p must be at least 1");
    end
  endgenerate

  localparam int cnt_w_lp = $clog2(stable_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(stable_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] one_lp      = cnt_w_lp'(1);

  logic [width_p-1:0]  sync1_q;
  logic [width_p-1:0]  sync2_q;
  logic [width_p-1:0]  level_q;
  logic [width_p-1:0]  rise_q;
  logic [width_p-1:0]  fall_q;
  logic [cnt_w_lp-1:0] cnt_q [width_p];

  // The counter only runs while sync2 disagrees with level, so any agreeing sample restarts it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < width_p; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_async_unsafe_i;
      sync2_q <= sync1_q;
      for (int i = 0; i < width_p; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == last_cnt_lp) begin
          cnt_q[i]   <= '0;
          level_q[i] <= sync2_q[i];
          rise_q[i]  <= sync2_q[i];
          fall_q[i]  <= ~sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + one_lp;
        end
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  logic [width_p-1:0] toggle_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ rise_q;
    end
  end

  assign toggle_o = toggle_q;
`else
  assign toggle_o = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed bench for button_debouncer (width_p=3, stable_cycles_p=4)
module tb_button_debouncer;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [2:0] btn;
  logic [2:0] level_o;
  logic [2:0] rise_o;
  logic [2:0] fall_o;
  logic [2:0] toggle_o;

  int passed = 0;
  int total  = 0;

  logic [2:0] tog_exp   = 3'b000;
  logic [2:0] rise_prev = 3'b000;

  button_debouncer #(
    .width_p        (3),
    .stable_cycles_p(4)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .btn_async_unsafe_i(btn),
    .level_o           (level_o),
    .rise_o            (rise_o),
    .fall_o            (fall_o),
    .toggle_o          (toggle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clock edge, then check every output against the expected values for that edge.
  task automatic step(input string tag, input logic [2:0] lvl, input logic [2:0] rise,
                      input logic [2:0] fall);
    @(posedge clk_i);
    #1;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    tog_exp = reset_i ? 3'b000 : (tog_exp ^ rise_prev);
`endif
    rise_prev = reset_i ? 3'b000 : rise;
    chk({tag, ".level"},  level_o,  lvl);
    chk({tag, ".rise"},   rise_o,   rise);
    chk({tag, ".fall"},   fall_o,   fall);
    chk({tag, ".toggle"}, toggle_o, tog_exp);
  endtask

  // Drive a new button value and expect acceptance on exactly the 6th edge after driving it.
  task automatic transition(input string tag, input logic [2:0] b, input logic [2:0] old_lvl,
                            input logic [2:0] new_lvl, input logic [2:0] rise,
                            input logic [2:0] fall);
    btn = b;
    for (int i = 1; i <= 5; i++) step($sformatf("%s.wait%0d", tag, i), old_lvl, 3'b000, 3'b000);
    step({tag, ".accept"}, new_lvl, rise, fall);
    step({tag, ".after"},  new_lvl, 3'b000, 3'b000);
  endtask

  initial begin
    reset_i = 1'b1;
    btn     = 3'b111;
    for (int i = 0; i < 3; i++) step($sformatf("reset%0d", i), 3'b000, 3'b000, 3'b000);

    reset_i = 1'b0;
    transition("post_reset", 3'b111, 3'b000, 3'b111, 3'b111, 3'b000);
    transition("release_all", 3'b000, 3'b111, 3'b000, 3'b000, 3'b111);
    transition("clean_press", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);

    btn = 3'b011; step("bounce0", 3'b001, 3'b000, 3'b000);
    btn = 3'b001; step("bounce1", 3'b001, 3'b000, 3'b000);
    btn = 3'b011; step("bounce2", 3'b001, 3'b000, 3'b000);
    btn = 3'b011; step("bounce3", 3'b001, 3'b000, 3'b000);
    btn = 3'b001; step("bounce4", 3'b001, 3'b000, 3'b000);
    transition("bounce_settle", 3'b011, 3'b001, 3'b011, 3'b010, 3'b000);

    transition("simultaneous", 3'b100, 3'b011, 3'b100, 3'b100, 3'b011);
    transition("release2", 3'b000, 3'b100, 3'b000, 3'b000, 3'b100);

    btn = 3'b100;
    for (int i = 1; i <= 4; i++) step($sformatf("midcount%0d", i), 3'b000, 3'b000, 3'b000);
    reset_i = 1'b1;
    step("midcount_reset", 3'b000, 3'b000, 3'b000);
    reset_i = 1'b0;
    transition("midcount_restart", 3'b100, 3'b000, 3'b100, 3'b100, 3'b000);

    transition("tog_press1",   3'b101, 3'b100, 3'b101, 3'b001, 3'b000);
    transition("tog_release1", 3'b100, 3'b101, 3'b100, 3'b000, 3'b001);
    transition("tog_press2",   3'b101, 3'b100, 3'b101, 3'b001, 3'b000);
    transition("tog_release2", 3'b100, 3'b101, 3'b100, 3'b000, 3'b001);
    transition("tog_press3",   3'b101, 3'b100, 3'b101, 3'b001, 3'b000);

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    chk("toggle_final", toggle_o, 3'b101);
`else
    chk("toggle_final", toggle_o, 3'b000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
